// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular buffer that retires decoded instructions in program order.
// Latency: issue at edge N, earliest CDB capture at N+1, commit pulse registered at N+2; one commit per cycle.
// Backpressure: success drops when full, during the flush cycle or while rdy is low; rdy low freezes all state.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_has_rd,
    input  logic             issue_is_branch,
    input  logic             issue_is_store,
    input  logic             issue_pred_taken,
    input  logic [31:0]      issue_alt_pc,
    output logic             success,
    output logic [TAG_W-1:0] ROB_Tail,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_taken,
    input  logic [TAG_W-1:0] qry_tag_a,
    input  logic [TAG_W-1:0] qry_tag_b,
    output logic             qry_ready_a,
    output logic             qry_ready_b,
    output logic [31:0]      qry_value_a,
    output logic [31:0]      qry_value_b,
    output logic             ROB_Ready,
    output logic [4:0]       ROB_Addr,
    output logic [31:0]      ROB_Value,
    output logic [TAG_W-1:0] ROB_Tag,
    output logic             store_commit,
    output logic             flush,
    output logic [31:0]      redirect_pc
);

    typedef struct packed {
        logic [4:0]  rd;
        logic        has_rd;
        logic        is_branch;
        logic        is_store;
        logic        pred;
        logic [31:0] alt_pc;
        logic [31:0] value;
        logic        taken;
    } entry_t;

    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [DEPTH-1:0]   done_q, done_d;
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [TAG_W:0]     count_q, count_d;
    logic               rob_ready_q, rob_ready_d;
    logic               store_commit_q, store_commit_d;
    logic               flush_q, flush_d;
    logic [4:0]         rob_addr_q, rob_addr_d;
    logic [31:0]        rob_value_q, rob_value_d;
    logic [TAG_W-1:0]   rob_tag_q, rob_tag_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    entry_t             head_ent;
    logic               commit;
    logic               mispredict;
    logic               flush_out;
    logic               do_issue;

    // Qualify this cycle's commit and issue from registered state only
    always_comb begin
        head_ent   = ent_q[head_q];
        commit     = rdy && busy_q[head_q] && done_q[head_q];
        mispredict = commit && head_ent.is_branch && (head_ent.taken != head_ent.pred);
        flush_out  = flush_q && rdy;
        success    = rdy && (count_q != CNT_FULL) && !flush_out;
        do_issue   = issue_valid && success;
    end

    // Next state: capture CDB, allocate at tail, retire at head (a mispredict wipes everything)
    always_comb begin
        ent_d          = ent_q;
        busy_d         = busy_q;
        done_d         = done_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        rob_ready_d    = 1'b0;
        store_commit_d = 1'b0;
        flush_d        = 1'b0;
        rob_addr_d     = rob_addr_q;
        rob_value_d    = rob_value_q;
        rob_tag_d      = rob_tag_q;
        redirect_pc_d  = redirect_pc_q;

        if (rdy) begin
            // Results for entries that are not in flight are dropped
            if (cdb_valid && busy_q[cdb_tag]) begin
                done_d[cdb_tag]        = 1'b1;
                ent_d[cdb_tag].value   = cdb_value;
                ent_d[cdb_tag].taken   = cdb_taken;
            end

            // Stores carry no result, so they are complete from the moment they issue
            if (do_issue) begin
                ent_d[tail_q].rd        = issue_rd;
                ent_d[tail_q].has_rd    = issue_has_rd;
                ent_d[tail_q].is_branch = issue_is_branch;
                ent_d[tail_q].is_store  = issue_is_store;
                ent_d[tail_q].pred      = issue_pred_taken;
                ent_d[tail_q].alt_pc    = issue_alt_pc;
                ent_d[tail_q].value     = 32'd0;
                ent_d[tail_q].taken     = 1'b0;
                busy_d[tail_q]          = 1'b1;
                done_d[tail_q]          = issue_is_store;
                tail_d                  = tail_q + TAG_W'(1);
            end

            count_d = count_q + (TAG_W+1)'(do_issue) - (TAG_W+1)'(commit);

            if (mispredict) begin
                flush_d       = 1'b1;
                redirect_pc_d = head_ent.alt_pc;
                busy_d        = '0;
                done_d        = '0;
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
            end else if (commit) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + TAG_W'(1);
                if (head_ent.is_branch) begin
                    rob_ready_d = 1'b0;
                end else if (head_ent.is_store) begin
                    store_commit_d = 1'b1;
                end else if (head_ent.has_rd && (head_ent.rd != 5'd0)) begin
                    rob_ready_d = 1'b1;
                    rob_addr_d  = head_ent.rd;
                    rob_value_d = head_ent.value;
                    rob_tag_d   = head_q;
                end
            end
        end
    end

    // State registers; reset discards every in-flight entry at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            rob_ready_q    <= 1'b0;
            store_commit_q <= 1'b0;
            flush_q        <= 1'b0;
            rob_addr_q     <= '0;
            rob_value_q    <= '0;
            rob_tag_q      <= '0;
            redirect_pc_q  <= '0;
        end else begin
            ent_q          <= ent_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            rob_ready_q    <= rob_ready_d;
            store_commit_q <= store_commit_d;
            flush_q        <= flush_d;
            rob_addr_q     <= rob_addr_d;
            rob_value_q    <= rob_value_d;
            rob_tag_q      <= rob_tag_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign ROB_Tail     = tail_q;
    assign ROB_Ready    = rob_ready_q && rdy;
    assign store_commit = store_commit_q && rdy;
    assign flush        = flush_out;
    assign ROB_Addr     = rob_addr_q;
    assign ROB_Value    = rob_value_q;
    assign ROB_Tag      = rob_tag_q;
    assign redirect_pc  = redirect_pc_q;

    assign qry_ready_a  = busy_q[qry_tag_a] && done_q[qry_tag_a] && !flush_out;
    assign qry_ready_b  = busy_q[qry_tag_b] && done_q[qry_tag_b] && !flush_out;
    assign qry_value_a  = ent_q[qry_tag_a].value;
    assign qry_value_b  = ent_q[qry_tag_b].value;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 16-entry reorder buffer between the instruction decoder/register file and the execution units. It accepts decoded instructions in program order and returns each one's tag as `ROB_Tail`. It captures results from the common data bus and retires one instruction per cycle in order, sending a register write-back pulse to the register file. On a mispredicted branch it raises a flush and a redirect PC.

## Interface
- `DEPTH`, 16, entry count; must be a power of two.
- `TAG_W`, 4, tag / pointer width; equals log2(`DEPTH`).
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  when low, all state is held and output pulses are forced low.
- `issue_valid`  in  1  decoder presents an instruction.
- `issue_rd`  in  5  destination register.
- `issue_has_rd`  in  1  instruction writes `issue_rd`.
- `issue_is_branch`  in  1  conditional branch.
- `issue_is_store`  in  1  store.
- `issue_pred_taken`  in  1  predictor decision for the branch.
- `issue_alt_pc`  in  32  PC to fetch if the prediction proves wrong.
- `success`  out  1  issue accepted this cycle (combinational).
- `ROB_Tail`  out  TAG_W  tag allocated to the instruction currently presented.
- `cdb_valid`  in  1  result broadcast.
- `cdb_tag`  in  TAG_W  entry being completed.
- `cdb_value`  in  32  result value.
- `cdb_taken`  in  1  resolved branch outcome.
- `qry_tag_a`, `qry_tag_b`  in  TAG_W  operand lookup tags.
- `qry_ready_a`, `qry_ready_b`  out  1  entry busy and done (combinational).
- `qry_value_a`, `qry_value_b`  out  32  entry value (combinational).
- `ROB_Ready`  out  1  one-cycle commit pulse to the register file.
- `ROB_Addr`  out  5  committed destination register.
- `ROB_Value`  out  32  committed value.
- `ROB_Tag`  out  TAG_W  committed entry's tag.
- `store_commit`  out  1  one-cycle pulse: a store has retired.
- `flush`  out  1  one-cycle mispredict flush.
- `redirect_pc`  out  32  new fetch PC, valid while `flush` is high.

## Operation
**Per-entry state**
- `busy`, `done`, `rd`, `has_rd`, `is_branch`, `is_store`, `pred`, `alt_pc`, `value`, `taken`.

**Pointers**
- Registers `head` and `tail` (TAG_W bits, wrapping 15→0) and `count` (TAG_W+1 bits).

**Issue**
- `success = (count != DEPTH) && !flush`.
- `ROB_Tail = tail`.
- When `issue_valid && success`:
  - write the entry at `tail` with `busy=1`, `done=0`;
  - `tail` increments.
- Stores issue with `done=1`; they need no write-back.

**Write-back**
- When `cdb_valid` and `busy[cdb_tag]`: set `done`, `value`, `taken`.
- A `cdb_valid` aimed at a non-busy entry is ignored.

**Commit**
- Fires when `busy[head] && done[head]`, evaluated on registered state. At most one commit per cycle.
- Branch with `taken == pred`:
  - free the entry;
  - no `ROB_Ready`.
- Branch with `taken != pred`:
  - `flush=1`, `redirect_pc=alt_pc`;
  - clear every `busy`;
  - `head=tail=count=0`.
- Store:
  - `store_commit=1`;
  - free the entry.
- Otherwise, if `has_rd && rd != 0`:
  - `ROB_Ready=1`, `ROB_Addr=rd`, `ROB_Value=value`, `ROB_Tag=head`.
- Every non-flush commit advances `head`.

**Count update**
- Issue and commit in the same cycle: `count` unchanged.
- Issue only: `count+1`. Commit only: `count-1`.
- A mispredict flush overrides any same-cycle issue; the issued instruction is dropped.

**Reset**
- All entries not busy; `head=tail=count=0`.
- All outputs 0, so `success=1` and `ROB_Tail=0`.
- Reset mid-operation discards every in-flight entry immediately.

## Timing
- Issue is accepted at edge N.
- The earliest CDB capture is at edge N+1 (the entry does not exist before edge N).
- Commit is registered at edge N+2: `ROB_Ready` is high from N+2 to N+3.
- A CDB completion of the head entry is never committed in the same edge it is captured. Commit latency from write-back is one edge.
- `ROB_Ready`, `store_commit` and `flush` are registered single-cycle pulses. They return to 0 the next edge unless another commit occurs.
- `ROB_Addr`, `ROB_Value` and `ROB_Tag` hold their last values.
- During the `flush` cycle:
  - `success=0`;
  - `qry_ready_*=0`.
- Full (`count=16`): `success=0`. A commit that edge frees space, so `success=1` on the following cycle.
- With `rdy=0`: no issue, no capture, no commit.
  - `success=0`.
  - Pulses are forced 0.
  - Pointers and entries hold.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all pulse outputs 0 immediately, `success=1`, `ROB_Tail=0`.
- **Basic commit:** issue `rd=5`; CDB tag 0 value 0x1234 next cycle → one edge later `ROB_Ready=1`, `ROB_Addr=5`, `ROB_Value=0x1234`, `ROB_Tag=0`, for exactly one cycle.
- **Full and wrap:** issue 16 with no CDB → `success=0` on the 17th attempt, `ROB_Tail=0`. Complete tags 0 and 1 → commits in order, `success=1` again. The next issue takes tag 0.
- **Out-of-order completion:** issue A (`rd=1`), then B (`rd=2`). CDB completes B before A → no commit until A completes, then A commits and B commits on the following cycle.
- **Mispredict:**
  - Issue branch with `pred=1`, `alt_pc=0x100`, followed by two ALU ops.
  - CDB `taken=0` on the branch.
  - Required: at the branch commit, `flush=1` and `redirect_pc=0x100`.
  - Required next cycle: `count=0`, `ROB_Tail=0`, and no `ROB_Ready` for the ops, even if their CDB results arrive.
- **Store and x0:**
  - Store at head → `store_commit` pulse, no `ROB_Ready`.
  - Completed op with `rd=0` → head advances, `ROB_Ready` stays 0.
